// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequencer between the execute stage and datamemory. Takes one READ,
//   WRITE or INCR (atomic read-add-write) request at a time over a
//   valid/ready handshake. It drives the datamemory address, writeEnable and
//   dataIn ports and samples its combinational dataOut. It returns exactly
//   one response per request over a second valid/ready handshake.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_op                  0=READ 1=WRITE 2=INCR 3=reserved (rejected)
//   req_addr, req_wdata     word address, write data / increment addend
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      response data, rejection flag
//   mem_address, mem_writeEnable, mem_dataIn, mem_dataOut
//                           datamemory interface
module mem_access_unit #(
    parameter int addresswidth = 7,
    parameter int depth        = 2 ** addresswidth,
    parameter int width        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [addresswidth-1:0] req_addr,
    input  logic [width-1:0]        req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [width-1:0]        rsp_rdata,
    output logic                    rsp_err,
    output logic [addresswidth-1:0] mem_address,
    output logic                    mem_writeEnable,
    output logic [width-1:0]        mem_dataIn,
    input  logic [width-1:0]        mem_dataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] op_read  = 2'd0;
    localparam logic [1:0] op_write = 2'd1;
    localparam logic [1:0] op_incr  = 2'd2;
    localparam logic [1:0] op_rsvd  = 2'd3;

    // One extra bit so a depth of exactly 2**addresswidth is representable.
    localparam logic [addresswidth:0] depth_c = (addresswidth + 1)'(depth);

    state_t                 state_r;
    logic [1:0]             op_r;
    logic [width-1:0]       addend_r;
    logic                   reject_s;

    // Reserved opcodes and addresses beyond the implemented words are
    // answered without touching memory.
    always_comb begin
        if ((req_op == op_rsvd) || ({1'b0, req_addr} >= depth_c)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Request sequencer; every output is a register so nothing glitches
    // toward datamemory or the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            op_r            <= op_read;
            addend_r        <= {width{1'b0}};
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= {width{1'b0}};
            rsp_err         <= 1'b0;
            mem_address     <= {addresswidth{1'b0}};
            mem_writeEnable <= 1'b0;
            mem_dataIn      <= {width{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        op_r        <= req_op;
                        addend_r    <= req_wdata;
                        mem_address <= req_addr;
                        req_ready   <= 1'b0;
                        if (reject_s) begin
                            state_r   <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {width{1'b0}};
                        end else if (req_op == op_write) begin
                            state_r         <= WR;
                            mem_dataIn      <= req_wdata;
                            mem_writeEnable <= 1'b1;
                        end else begin
                            state_r <= RD;
                        end
                    end
                end
                RD: begin
                    // dataOut has had a full cycle to settle on the held address.
                    if (op_r == op_incr) begin
                        state_r         <= WR;
                        mem_dataIn      <= mem_dataOut + addend_r;
                        mem_writeEnable <= 1'b1;
                    end else begin
                        state_r   <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= mem_dataOut;
                    end
                end
                WR: begin
                    // datamemory commits on this edge; report the written word.
                    state_r         <= RSP;
                    mem_writeEnable <= 1'b0;
                    rsp_valid       <= 1'b1;
                    rsp_err         <= 1'b0;
                    rsp_rdata       <= mem_dataIn;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    req_ready       <= 1'b1;
                    rsp_valid       <= 1'b0;
                    rsp_err         <= 1'b0;
                    mem_writeEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule
